// File: rtl/io_in_cond_pkg.sv
// Shared helpers for the input conditioning stage: default sizes and the
// debounce counter width derivation.
package io_in_cond_pkg;

   localparam int unsigned WIDTH_DEF           = 32;
   localparam int unsigned SYNC_STAGES_DEF     = 2;
   localparam int unsigned DEBOUNCE_CYCLES_DEF = 16;

   // Ceiling log2; clog2(1) = 0.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      int unsigned v;
      r = 0;
      v = (n > 0) ? n - 1 : 0;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

   // Debounce counter width, never less than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (clog2(n) < 1) ? 1 : clog2(n);
   endfunction

   localparam int unsigned DEB_CNT_W_DEF = cnt_width(DEBOUNCE_CYCLES_DEF);

endpackage

// File: rtl/io_debounce_bit.sv
// Single-bit synchroniser + debouncer with registered rise/fall pulses.
// Ports:
//   i_clk, i_rst     clock, async active-high reset
//   i_pin            raw asynchronous pin level
//   o_stable         debounced level
//   o_rise, o_fall   one-cycle pulses after the stable level changes
//   o_edge_nxt_c     combinational: stable level changes at this clock edge
module io_debounce_bit
   import io_in_cond_pkg::*;
#(
   parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_pin,
   output logic o_stable,
   output logic o_rise,
   output logic o_fall,
   output logic o_edge_nxt_c
);

   localparam int unsigned       CNT_W   = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic [CNT_W-1:0]       r_cnt;
   logic                   w_sync;
   logic                   w_update;

   assign w_sync       = r_sync[SYNC_STAGES-1];
   // Sync has disagreed with the stable value for DEBOUNCE_CYCLES edges.
   assign w_update     = (w_sync != o_stable) && (r_cnt == CNT_MAX);
   assign o_edge_nxt_c = w_update;

   // Synchroniser chain, plain flops only.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_sync <= '0;
      else       r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
   end

   // Debounce counter, stable level and edge pulses.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt    <= '0;
         o_stable <= 1'b0;
         o_rise   <= 1'b0;
         o_fall   <= 1'b0;
      end else begin
         o_rise <= w_update &  w_sync;
         o_fall <= w_update & ~w_sync;
         if (w_sync == o_stable) begin
            r_cnt <= '0;
         end else if (w_update) begin
            o_stable <= w_sync;
            r_cnt    <= '0;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/io_in_cond.sv
// Input conditioning for the I/O register block: per-bit synchronise and
// debounce, rise/fall pulses and a write-one-to-clear sticky edge word.
// Ports:
//   clk, rst            clock, async active-high reset
//   pins_in             raw asynchronous pin levels
//   io_in               debounced levels feeding the I/O block
//   rise, fall          one-cycle edge pulses per bit
//   edge_sticky         latched OR of rise|fall since last clear
//   clr_we, clr_mask    clear strobe and bit mask for edge_sticky
module io_in_cond
   import io_in_cond_pkg::*;
#(
   parameter int unsigned WIDTH           = WIDTH_DEF,
   parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] pins_in,
   output logic [WIDTH-1:0] io_in,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic [WIDTH-1:0] edge_sticky,
   input  logic             clr_we,
   input  logic [WIDTH-1:0] clr_mask
);

   logic [WIDTH-1:0] w_edge_nxt;
   logic [WIDTH-1:0] w_clr;

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      io_debounce_bit #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_bit (
         .i_clk        (clk),
         .i_rst        (rst),
         .i_pin        (pins_in[gi]),
         .o_stable     (io_in[gi]),
         .o_rise       (rise[gi]),
         .o_fall       (fall[gi]),
         .o_edge_nxt_c (w_edge_nxt[gi])
      );
   end

   assign w_clr = {WIDTH{clr_we}} & clr_mask;

   // Sticky edge word; a new edge overrides a simultaneous clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) edge_sticky <= '0;
      else     edge_sticky <= (edge_sticky & ~w_clr) | w_edge_nxt;
   end

endmodule

// File: tb/tb_io_in_cond.sv
module tb_io_in_cond;

   localparam int unsigned W    = 32;
   localparam int unsigned SYNC = 2;
   localparam int unsigned DEB  = 16;
   localparam int unsigned HL   = SYNC + DEB;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] pins_in;
   logic [W-1:0] io_in, rise, fall, edge_sticky;
   logic         clr_we;
   logic [W-1:0] clr_mask;

   int total = 0;
   int bad   = 0;

   // Reference model: history of pin levels seen at each edge.
   logic [W-1:0] hist [HL];
   logic [W-1:0] m_io, m_rise, m_fall, m_sticky;
   int           n_rise [W];
   int           n_fall [W];

   io_in_cond #(.WIDTH(W), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB)) dut (
      .clk         (clk),
      .rst         (rst),
      .pins_in     (pins_in),
      .io_in       (io_in),
      .rise        (rise),
      .fall        (fall),
      .edge_sticky (edge_sticky),
      .clr_we      (clr_we),
      .clr_mask    (clr_mask)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic mdl_reset();
      for (int k = 0; k < HL; k++) hist[k] = '0;
      m_io = '0; m_rise = '0; m_fall = '0; m_sticky = '0;
   endtask

   task automatic clr_counts();
      for (int b = 0; b < W; b++) begin
         n_rise[b] = 0;
         n_fall[b] = 0;
      end
   endtask

   // A bit flips once its synchronised level has disagreed with the stable
   // level on each of the last DEB edges; the synchroniser delays the pin by SYNC edges.
   task automatic mdl_edge();
      logic [W-1:0] flip;
      for (int k = HL - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = pins_in;
      flip = '1;
      for (int k = 0; k < DEB; k++) flip &= hist[SYNC + k] ^ m_io;
      m_rise   = flip & ~m_io;
      m_fall   = flip &  m_io;
      m_io     = m_io ^ flip;
      m_sticky = (m_sticky & ~(clr_we ? clr_mask : '0)) | flip;
   endtask

   task automatic step();
      @(posedge clk);
      if (rst) mdl_reset();
      else     mdl_edge();
      #1;
      chk("io_in",  io_in,       m_io);
      chk("rise",   rise,        m_rise);
      chk("fall",   fall,        m_fall);
      chk("sticky", edge_sticky, m_sticky);
      for (int b = 0; b < W; b++) begin
         if (rise[b] === 1'b1) n_rise[b]++;
         if (fall[b] === 1'b1) n_fall[b]++;
      end
   endtask

   // Steps until io_in[b] reaches v; n = edges taken, -1 if the bound expires.
   task automatic wait_bit(input int b, input logic v, output int n);
      n = -1;
      for (int i = 1; i <= 60; i++) begin
         step();
         if (io_in[b] === v) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic clear_all();
      clr_we = 1'b1; clr_mask = '1;
      step();
      clr_we = 1'b0; clr_mask = '0;
   endtask

   initial begin
      int n;
      rst = 1'b1; pins_in = '1; clr_we = 1'b0; clr_mask = '0;
      mdl_reset();
      clr_counts();
      #1;
      chk("reset_io", io_in, '0);
      chk("reset_sticky", edge_sticky, '0);

      // Reset with all pins high, then release.
      repeat (3) step();
      rst = 1'b0;
      wait_bit(0, 1'b1, n);
      chk("por_latency", 32'(n), 32'd18);
      chk("por_io", io_in, '1);
      chk("por_rise", rise, '1);
      chk("por_sticky", edge_sticky, '1);
      repeat (3) step();
      chk("por_rise_once", 32'(n_rise[31]), 32'd1);

      // Drop all pins, settle, clear.
      pins_in = '0;
      repeat (20) step();
      clear_all();

      // Glitch on bit 3 shorter than the debounce window.
      pins_in[3] = 1'b1;
      repeat (10) step();
      pins_in[3] = 1'b0;
      repeat (20) step();
      chk("glitch_io", io_in, '0);
      chk("glitch_sticky", edge_sticky, '0);
      pins_in[3] = 1'b1;
      wait_bit(3, 1'b1, n);
      chk("hold3_latency", 32'(n), 32'd18);

      // Bounce on bit 5.
      clr_counts();
      pins_in[5] = 1'b1; repeat (5) step();
      pins_in[5] = 1'b0; repeat (5) step();
      pins_in[5] = 1'b1;
      wait_bit(5, 1'b1, n);
      chk("bounce_latency", 32'(n), 32'd18);
      repeat (10) step();
      chk("bounce_rise_cnt", 32'(n_rise[5]), 32'd1);

      // Fall on bit 0.
      pins_in[0] = 1'b1;
      repeat (20) step();
      clear_all();
      clr_counts();
      pins_in[0] = 1'b0;
      repeat (25) step();
      chk("fall_cnt", 32'(n_fall[0]), 32'd1);
      chk("fall_no_rise", 32'(n_rise[0]), 32'd0);
      chk("fall_sticky0", 32'(edge_sticky[0]), 32'd1);

      // Clear colliding with a new rise on bit 0.
      clear_all();
      pins_in[0] = 1'b1;
      repeat (17) step();
      clr_we = 1'b1; clr_mask = 32'h1;
      step();
      chk("coll_rise0", 32'(rise[0]), 32'd1);
      chk("coll_sticky0", 32'(edge_sticky[0]), 32'd1);
      step();
      chk("clr_sticky0", 32'(edge_sticky[0]), 32'd0);
      clr_we = 1'b0; clr_mask = '0;

      // Asynchronous reset in the middle of a debounce on bit 7.
      pins_in[7] = 1'b1;
      repeat (12) step();
      #3 rst = 1'b1;
      mdl_reset();
      #1;
      chk("async_io", io_in, '0);
      chk("async_rise", rise, '0);
      chk("async_fall", fall, '0);
      chk("async_sticky", edge_sticky, '0);
      #1 rst = 1'b0;
      wait_bit(7, 1'b1, n);
      chk("post_rst_latency", 32'(n), 32'd18);

      // Randomised pins and clears against the model.
      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(0, 11) == 0) pins_in = pins_in ^ ($urandom & $urandom);
         clr_we   = ($urandom_range(0, 3) == 0);
         clr_mask = $urandom;
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
